// File: rtl/inst_fetch_if.sv
// IF-side bundle: stall/redirect inputs from the pipeline, the IF->ID bus and
// the instruction SRAM read port.
interface inst_fetch_if;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  modport master (
    input  stall, br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output stall, br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, applies ID redirects, drives the SRAM
// so read data lines up with the pc ID holds next cycle, and halts on bad targets.
//
// state | meaning
// RST   | out of reset, no instruction issued yet
// RUN   | fetching normally
// HALT  | misaligned redirect taken; fetch frozen until rst
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  inst_fetch_if.master     fif,
  output logic             fetch_halt,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_HALT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             ce_q, ce_d;
  logic [31:0]      id_pc_m_q, id_pc_m_d;
  logic             id_ce_m_q, id_ce_m_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        stall_if, stall_id, stall_ex;
  logic        sram_en;
  logic [31:0] sram_addr;
  logic        unused_stall;

  assign br_e         = fif.br_bus[32];
  assign br_addr      = fif.br_bus[31:0];
  assign stall_if     = fif.stall[0];
  assign stall_id     = fif.stall[1];
  assign stall_ex     = fif.stall[2];
  assign unused_stall = ^fif.stall[5:3];
  assign next_pc      = br_e ? br_addr : pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RST;
      pc_q           <= RESET_PC - 32'd4;
      ce_q           <= 1'b0;
      id_pc_m_q      <= '0;
      id_ce_m_q      <= 1'b0;
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ce_q           <= ce_d;
      id_pc_m_q      <= id_pc_m_d;
      id_ce_m_q      <= id_ce_m_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ce_d           = ce_q;
    redirect_cnt_d = redirect_cnt_q;
    if (state_q != ST_HALT && !stall_if) begin
      if (br_e) redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      if (br_e && br_addr[1:0] != 2'b00) begin
        pc_d    = br_addr;
        ce_d    = 1'b0;
        state_d = ST_HALT;
      end else begin
        pc_d    = next_pc;
        ce_d    = 1'b1;
        state_d = ST_RUN;
      end
    end
  end

  // Mirror of ID's input register, so a held ID can have its word re-read.
  always_comb begin
    id_pc_m_d = id_pc_m_q;
    id_ce_m_d = id_ce_m_q;
    if (!stall_id) begin
      id_pc_m_d = pc_q;
      id_ce_m_d = ce_q;
    end else if (!stall_ex) begin
      id_pc_m_d = '0;
      id_ce_m_d = 1'b0;
    end
  end

  always_comb begin
    sram_addr = pc_q;
    sram_en   = 1'b0;
    if (!stall_id) begin
      sram_en = ce_q;
    end else if (stall_ex) begin
      sram_addr = id_pc_m_q;
      sram_en   = id_ce_m_q;
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (!stall_id && sram_en) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
  end

  assign fif.if_to_id_bus    = {ce_q, pc_q};
  assign fif.inst_sram_en    = sram_en;
  assign fif.inst_sram_addr  = sram_addr;
  assign fif.inst_sram_wen   = 4'b0000;
  assign fif.inst_sram_wdata = 32'd0;
  assign fetch_halt          = (state_q == ST_HALT);
  assign fetch_cnt           = fetch_cnt_q;
  assign redirect_cnt        = redirect_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, sequential fetch, stalls, redirect,
// misaligned-redirect halt and reset out of halt.
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_halt;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
  int          n_chk = 0;
  int          n_bad = 0;

  inst_fetch_if fif();

  inst_fetch #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .fif          (fif),
    .fetch_halt   (fetch_halt),
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    fif.stall  = 6'b0;
    fif.br_bus = 33'b0;
    repeat (2) step();
    chk("rst_bus",   64'(fif.if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
    chk("rst_halt",  64'(fetch_halt), 64'd0);
    chk("rst_fcnt",  64'(fetch_cnt), 64'd0);
    chk("rst_rcnt",  64'(redirect_cnt), 64'd0);
    chk("rst_addr",  64'(fif.inst_sram_addr), 64'(32'hBFBF_FFFC));
    chk("rst_en",    64'(fif.inst_sram_en), 64'd0);
    chk("wen",       64'(fif.inst_sram_wen), 64'd0);
    chk("wdata",     64'(fif.inst_sram_wdata), 64'd0);

    rst = 1'b0;
    step();
    chk("e1_bus",  64'(fif.if_to_id_bus), 64'({1'b1, RPC}));
    chk("e1_addr", 64'({fif.inst_sram_en, fif.inst_sram_addr}), 64'({1'b1, RPC}));
    step();
    chk("e2_mir",  64'({dut.id_ce_m_q, dut.id_pc_m_q}), 64'({1'b1, RPC}));
    chk("e2_addr", 64'(fif.inst_sram_addr), 64'(32'hBFC0_0004));
    step();
    chk("e3_mir",  64'(dut.id_pc_m_q), 64'(32'hBFC0_0004));
    step();
    chk("e4_mir",  64'(dut.id_pc_m_q), 64'(32'hBFC0_0008));
    chk("e4_fcnt", 64'(fetch_cnt), 64'd3);
    chk("e4_pc",   64'(fif.if_to_id_bus), 64'({1'b1, 32'hBFC0_000C}));

    // load-use stall: re-read the word ID holds
    fif.stall = 6'b000111;
    #1;
    chk("lu_addr0", 64'({fif.inst_sram_en, fif.inst_sram_addr}), 64'({1'b1, 32'hBFC0_0008}));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lu_pc",   64'(fif.if_to_id_bus), 64'({1'b1, 32'hBFC0_000C}));
      chk("lu_fcnt", 64'(fetch_cnt), 64'd3);
      chk("lu_addr", 64'({fif.inst_sram_en, fif.inst_sram_addr}), 64'({1'b1, 32'hBFC0_0008}));
    end
    fif.stall = 6'b0;
    #1;
    chk("lu_rel", 64'({fif.inst_sram_en, fif.inst_sram_addr}), 64'({1'b1, 32'hBFC0_000C}));
    step();
    chk("lu_fcnt2", 64'(fetch_cnt), 64'd4);

    // bubble stall
    fif.stall = 6'b000011;
    #1;
    chk("bb_en", 64'(fif.inst_sram_en), 64'd0);
    step();
    chk("bb_mir", 64'({dut.id_ce_m_q, dut.id_pc_m_q}), 64'd0);
    chk("bb_pc",  64'(fif.if_to_id_bus), 64'({1'b1, 32'hBFC0_0010}));
    fif.stall = 6'b0;
    #1;
    chk("bb_rel", 64'({fif.inst_sram_en, fif.inst_sram_addr}), 64'({1'b1, 32'hBFC0_0010}));
    step();
    chk("bb_fcnt", 64'(fetch_cnt), 64'd5);

    // aligned branch
    fif.br_bus = {1'b1, 32'hBFC0_0100};
    step();
    fif.br_bus = 33'b0;
    chk("br_pc",   64'(fif.if_to_id_bus), 64'({1'b1, 32'hBFC0_0100}));
    chk("br_mir",  64'(dut.id_pc_m_q), 64'(32'hBFC0_0014));
    chk("br_rcnt", 64'(redirect_cnt), 64'd1);

    // branch ignored while IF stalled
    fif.stall  = 6'b000011;
    fif.br_bus = {1'b1, 32'hBFC0_0200};
    step();
    chk("bs_pc",   64'(fif.if_to_id_bus), 64'({1'b1, 32'hBFC0_0100}));
    chk("bs_rcnt", 64'(redirect_cnt), 64'd1);
    fif.stall  = 6'b0;
    fif.br_bus = 33'b0;
    step();
    chk("bs_pc2",  64'(fif.if_to_id_bus), 64'({1'b1, 32'hBFC0_0104}));
    chk("bs_fcnt", 64'(fetch_cnt), 64'd7);

    // misaligned redirect -> HALT
    fif.br_bus = {1'b1, 32'hBFC0_0102};
    step();
    fif.br_bus = 33'b0;
    chk("ha_halt", 64'(fetch_halt), 64'd1);
    chk("ha_bus",  64'(fif.if_to_id_bus), 64'({1'b0, 32'hBFC0_0102}));
    chk("ha_en",   64'(fif.inst_sram_en), 64'd0);
    chk("ha_rcnt", 64'(redirect_cnt), 64'd2);
    chk("ha_fcnt", 64'(fetch_cnt), 64'd8);
    fif.br_bus = {1'b1, 32'hBFC0_0200};
    step();
    fif.br_bus = 33'b0;
    chk("ha_hold", 64'(fif.if_to_id_bus), 64'({1'b0, 32'hBFC0_0102}));
    chk("ha_rc2",  64'(redirect_cnt), 64'd2);
    chk("ha_fc2",  64'(fetch_cnt), 64'd8);
    fif.stall = 6'b000111;
    #1;
    chk("ha_en_lu", 64'(fif.inst_sram_en), 64'd0);
    fif.stall = 6'b000011;
    #1;
    chk("ha_en_bb", 64'(fif.inst_sram_en), 64'd0);

    // reset out of HALT (mid-stall)
    rst = 1'b1;
    step();
    rst       = 1'b0;
    fif.stall = 6'b0;
    #1;
    chk("rh_bus",  64'(fif.if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
    chk("rh_halt", 64'(fetch_halt), 64'd0);
    chk("rh_fcnt", 64'(fetch_cnt), 64'd0);
    chk("rh_rcnt", 64'(redirect_cnt), 64'd0);
    step();
    chk("rh_bus1", 64'(fif.if_to_id_bus), 64'({1'b1, RPC}));
    step();
    chk("rh_mir",  64'({dut.id_ce_m_q, dut.id_pc_m_q}), 64'({1'b1, RPC}));
    chk("rh_fcnt1", 64'(fetch_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
